// File: rtl/mult_div_sequencer.sv
// Iterative signed mult/div (one op in flight); MD_DIV0_TRAP_EN short-circuits divide-by-zero with a div0 pulse.
// Latency: done in the (WIDTH+3)th cycle after start is accepted (3rd when trapping); start is ignored while busy.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic               op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH:0]     mag_a, mag_b;
  logic               neg_res, neg_rem;
  logic [WIDTH:0]     rh;
  logic [WIDTH-1:0]   ql;
  logic [CW-1:0]      cnt;
  logic               load_ok;

  // Magnitudes need WIDTH+1 bits so that |most-negative| is representable.
  logic [WIDTH:0]     abs_a, abs_b;
  logic [WIDTH+1:0]   msum;
  logic [WIDTH:0]     dshift, ddiff;
  logic               dge;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign abs_a = a_q[WIDTH-1] ? ({1'b0, ~a_q} + (WIDTH+1)'(1)) : {1'b0, a_q};
  assign abs_b = b_q[WIDTH-1] ? ({1'b0, ~b_q} + (WIDTH+1)'(1)) : {1'b0, b_q};

  // Multiply: {rh, ql} is the accumulator/multiplier pair, shifted right each step.
  assign msum = {1'b0, rh} + (ql[0] ? {1'b0, mag_a} : '0);

  // Divide: restoring step, ql shifts the dividend out and the quotient in.
  assign dshift = {rh[WIDTH-1:0], ql[WIDTH-1]};
  assign dge    = (dshift >= mag_b);
  assign ddiff  = dshift - mag_b;

  assign prod_mag = {rh[WIDTH-1:0], ql};
  assign prod_fix = neg_res ? -prod_mag : prod_mag;
  assign q_fix    = neg_res ? -ql : ql;
  assign r_fix    = neg_rem ? -rh[WIDTH-1:0] : rh[WIDTH-1:0];

`ifdef MD_DIV0_TRAP_EN
  logic trap_q;
  logic trap_hit;
  assign trap_hit = op_q && (b_q == '0);
  assign load_ok  = !trap_q;
  assign div0     = (state == DONE) && trap_q;
`else
  assign load_ok  = 1'b1;
  assign div0     = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = PREP;
      PREP: begin
`ifdef MD_DIV0_TRAP_EN
        // Trapped divides skip the iterations; FIX leaves hi/lo untouched.
        state_nxt = trap_hit ? FIX : ITER;
`else
        state_nxt = ITER;
`endif
      end
      ITER: if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      rh      <= '0;
      ql      <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
`ifdef MD_DIV0_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        PREP: begin
          mag_a   <= abs_a;
          mag_b   <= abs_b;
          neg_res <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          neg_rem <= a_q[WIDTH-1];
          rh      <= '0;
          cnt     <= '0;
          ql      <= op_q ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0];
`ifdef MD_DIV0_TRAP_EN
          trap_q  <= trap_hit;
`endif
        end
        ITER: begin
          cnt <= cnt + CW'(1);
          if (op_q) begin
            rh <= dge ? ddiff : dshift;
            ql <= {ql[WIDTH-2:0], dge};
          end else begin
            rh <= msum[WIDTH+1:1];
            ql <= {msum[0], ql[WIDTH-1:1]};
          end
        end
        FIX: begin
          // Results land here so hi/lo are already valid while done is high.
          if (load_ok) begin
            if (op_q) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: signed mult/div vectors, latency, busy, start/reset corner cases.
module tb_mult_div_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_div_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op; operands are scrambled after acceptance to prove they were latched.
  task automatic do_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output int busy_n, output logic d0);
    @(negedge clock);
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clock);
    start = 1'b0; a = ~av; b = ~bv; op = ~o;
    lat = -1; busy_n = 0; d0 = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n > 1) @(negedge clock);
      if (busy) busy_n++;
      if (done) begin
        lat = n;
        d0  = div0;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el);
    int lat, bn;
    logic d0;
    do_op(o, av, bv, lat, bn, d0);
    check_eq({tag, ".lat"}, lat, 35);
    check_eq({tag, ".busy_cycles"}, bn, 35);
    check_eq({tag, ".hi"}, hi, eh);
    check_eq({tag, ".lo"}, lo, el);
    check_eq({tag, ".div0"}, d0, 0);
    @(negedge clock);
    check_eq({tag, ".done_after"}, done, 0);
    check_eq({tag, ".busy_after"}, busy, 0);
    check_eq({tag, ".hold"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    int lat, bn, second;
    logic d0, done_seen;
    logic [63:0] prev;

    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.div0", div0, 0);
    check_eq("rst.hilo", {hi, lo}, 64'd0);
    reset = 1'b1;

    run_vec("mul_m3x5",   1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_vec("mul_max",    1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
    run_vec("mul_6x7",    1'b0, 32'd6,        32'd7,        32'h00000000, 32'h0000002A);
    run_vec("mul_minsq",  1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_vec("mul_minxm1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_vec("div_m7d2",   1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_vec("div_mindm1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_vec("div_100dm7", 1'b1, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);
    run_vec("div_m100dm7",1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E);
    run_vec("div_10d3",   1'b1, 32'd10,       32'd3,        32'h00000001, 32'h00000003);

    // Divide by zero
    prev = {hi, lo};
    do_op(1'b1, 32'd7, 32'd0, lat, bn, d0);
`ifdef MD_DIV0_TRAP_EN
    check_eq("div0.lat", lat, 3);
    check_eq("div0.flag", d0, 1);
    check_eq("div0.hilo_kept", {hi, lo}, prev);
    @(negedge clock);
    check_eq("div0.flag_pulse", div0, 0);
`else
    check_eq("div0.lat", lat, 35);
    check_eq("div0.flag", d0, 0);
    check_eq("div0.hilo", {hi, lo}, {32'd7, 32'hFFFFFFFF});
`endif

    // Second start mid-operation is ignored
    @(negedge clock);
    op = 1'b1; a = 32'd10; b = 32'd3; start = 1'b1;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (n == 1) start = 1'b0;
      if (n == 10) begin start = 1'b1; a = 32'd100; end
      if (n == 11) start = 1'b0;
      if (done) begin lat = n; break; end
    end
    check_eq("restart.lat", lat, 35);
    check_eq("restart.hilo", {hi, lo}, {32'd1, 32'd3});

    // Reset mid-operation
    @(negedge clock);
    op = 1'b1; a = 32'd10; b = 32'd3; start = 1'b1;
    done_seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 1) start = 1'b0;
      if (n == 10) begin start = 1'b1; a = 32'd100; end
      if (n == 11) start = 1'b0;
      done_seen = done_seen | done;
    end
    reset = 1'b0;
    #1;
    check_eq("midrst.busy", busy, 0);
    check_eq("midrst.hilo", {hi, lo}, 64'd0);
    check_eq("midrst.done", done, 0);
    repeat (2) begin
      @(negedge clock);
      done_seen = done_seen | done;
    end
    check_eq("midrst.no_done", done_seen, 0);
    reset = 1'b1;
    run_vec("post_rst_10d3", 1'b1, 32'd10, 32'd3, 32'h00000001, 32'h00000003);

    // start held high across DONE->IDLE is accepted in the IDLE cycle
    @(negedge clock);
    op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
    lat = -1; second = -1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clock);
      if (n == 36) check_eq("held.idle_gap", busy, 0);
      if (n == 37) begin
        check_eq("held.reaccept", busy, 1);
        start = 1'b0;
      end
      if (done) begin
        if (lat < 0) lat = n;
        else begin second = n; break; end
      end
    end
    check_eq("held.first", lat, 35);
    check_eq("held.second", second, 71);
    check_eq("held.hilo", {hi, lo}, {32'd0, 32'd42});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
